fifo_read_adapter: RTL and testbench



---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_read_adapter_if.sv | 32 +++
 rtl/fifo_read_adapter_skid_buffer2.sv | 71 +++++++
 rtl/fifo_read_adapter.sv | 87 ++++++++
 tb/tb_fifo_read_adapter.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the async FIFO read-side path.
//   FIFO_RD_LATENCY  registered read latency of the FIFO (cycles)
//   SKID_DEPTH       entries in the read-side skid buffer
//   OCC_*            occupancy state encoding of the skid buffer
//   DEF_*            default widths for the read adapter
package fifo_pkg;

   localparam int unsigned FIFO_RD_LATENCY = 1;
   localparam int unsigned SKID_DEPTH      = 2;
   localparam int unsigned DEF_DATA_WIDTH  = 32;
   localparam int unsigned DEF_CNT_WIDTH   = 16;

   localparam logic [1:0] OCC_EMPTY = 2'd0;
   localparam logic [1:0] OCC_ONE   = 2'd1;
   localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/fifo_read_adapter_if.sv
// fifo_read_adapter_if: FIFO read port plus consumer stream of the read adapter.
//   master : adapter side (drives fifo_ren, out_valid, out_data, occupancy,
//            words_out, parity_err)
//   slave  : environment side (drives fifo_empty, fifo_rdata, out_ready)
interface fifo_read_adapter_if
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
);

   logic                  fifo_empty;
   logic [DATA_WIDTH:0]   fifo_rdata;
   logic                  fifo_ren;
   logic                  out_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [1:0]            occupancy;
   logic [CNT_WIDTH-1:0]  words_out;
   logic                  parity_err;

   modport master (
      input  fifo_empty, fifo_rdata, out_ready,
      output fifo_ren, out_valid, out_data, occupancy, words_out, parity_err
   );

   modport slave (
      output fifo_empty, fifo_rdata, out_ready,
      input  fifo_ren, out_valid, out_data, occupancy, words_out, parity_err
   );

endinterface

// File: rtl/fifo_read_adapter_skid_buffer2.sv
// skid_buffer2: 2-entry in-order buffer with 1-bit head/tail pointers.
//   clk, resetn : clock, synchronous active-low reset
//   push, wdata : write wdata into the tail entry
//   pop         : retire the head entry (ignored while empty)
//   rdata       : head entry payload
//   occ, valid  : entries in use (0..2), occ != 0
module skid_buffer2
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [1:0]            occ,
   output logic                  valid
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic                  head_q;
   logic                  tail_q;
   logic [1:0]            occ_q;
   logic [1:0]            occ_d;
   logic                  pop_ok;

   assign pop_ok = pop & (occ_q != OCC_EMPTY);

   // Occupancy state register, storage and pointers
   always_ff @(posedge clk) begin
      if (!resetn) begin
         occ_q    <= OCC_EMPTY;
         head_q   <= 1'b0;
         tail_q   <= 1'b0;
         mem_q[0] <= '0;
         mem_q[1] <= '0;
      end else begin
         occ_q <= occ_d;
         if (push) begin
            mem_q[tail_q] <= wdata;
            tail_q        <= ~tail_q;
         end
         if (pop_ok) begin
            head_q <= ~head_q;
         end
      end
   end

   // Occupancy next state; simultaneous push and pop leave it unchanged
   always_comb begin
      occ_d = occ_q;
      case (occ_q)
         OCC_EMPTY: if (push)                occ_d = OCC_ONE;
         OCC_ONE:   if (push && !pop_ok)     occ_d = OCC_TWO;
                    else if (pop_ok && !push) occ_d = OCC_EMPTY;
         OCC_TWO:   if (pop_ok && !push)     occ_d = OCC_ONE;
         default:                            occ_d = OCC_EMPTY;
      endcase
   end

   assign rdata = mem_q[head_q];
   assign occ   = occ_q;
   assign valid = (occ_q != OCC_EMPTY);

   // Credit logic upstream must never push into a full buffer without a pop
   a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
      !(push && !pop_ok && (occ_q == OCC_TWO)));

endmodule

// File: rtl/fifo_read_adapter.sv
// fifo_read_adapter: read-side stage behind the async FIFO (r_clk domain).
// Issues read enables with credit so at most two words are buffered or in
// flight, absorbs the FIFO's registered read latency, and presents a
// valid/ready stream with a wrapping delivered-word counter.
//   clk, resetn : read clock, synchronous active-low reset (shared with FIFO)
//   bus.master  : fifo_empty/fifo_rdata/fifo_ren, out_ready/out_valid/out_data,
//                 occupancy, words_out, parity_err
// Build option FIFO_RD_PARITY_EN: flag a sticky error on odd parity of the
// full DATA_WIDTH+1 bit FIFO word; otherwise parity_err is tied to 0.
module fifo_read_adapter
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
   input logic                clk,
   input logic                resetn,
   fifo_read_adapter_if.master bus
);

   logic                  inflight_q;
   logic                  push_c;
   logic                  pop_c;
   logic                  ren_c;
   logic [2:0]            credit_c;
   logic                  skid_valid;
   logic [1:0]            skid_occ;
   logic [DATA_WIDTH-1:0] skid_rdata;
   logic [CNT_WIDTH-1:0]  words_q;
   logic                  perr_q;

   assign push_c = inflight_q;
   assign pop_c  = skid_valid & bus.out_ready;

   // Combinational from out_ready: a pop this cycle frees a slot for a read now
   assign credit_c = 3'(skid_occ) + 3'(inflight_q) - 3'(pop_c);
   assign ren_c    = resetn & ~bus.fifo_empty & (credit_c < 3'(SKID_DEPTH));

   skid_buffer2 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk    (clk),
      .resetn (resetn),
      .push   (push_c),
      .pop    (pop_c),
      .wdata  (bus.fifo_rdata[DATA_WIDTH-1:0]),
      .rdata  (skid_rdata),
      .occ    (skid_occ),
      .valid  (skid_valid)
   );

   // Read-latency tracker and delivered-word counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         inflight_q <= 1'b0;
         words_q    <= '0;
      end else begin
         inflight_q <= ren_c;
         if (pop_c) begin
            words_q <= words_q + CNT_WIDTH'(1);
         end
      end
   end

`ifdef FIFO_RD_PARITY_EN
   // Sticky even-parity check over the whole FIFO word; data still delivered
   always_ff @(posedge clk) begin
      if (!resetn) begin
         perr_q <= 1'b0;
      end else if (push_c && (^bus.fifo_rdata)) begin
         perr_q <= 1'b1;
      end
   end
`else
   logic unused_parity_bit;
   assign unused_parity_bit = bus.fifo_rdata[DATA_WIDTH];
   assign perr_q            = 1'b0;
`endif

   assign bus.fifo_ren   = ren_c;
   assign bus.out_valid  = skid_valid;
   assign bus.out_data   = skid_rdata;
   assign bus.occupancy  = skid_occ;
   assign bus.words_out  = words_q;
   assign bus.parity_err = perr_q;

endmodule

// File: tb/tb_fifo_read_adapter.sv
// tb_fifo_read_adapter: directed + random stimulus against a queue-based
// model of the read adapter and its FIFO environment.
module tb_fifo_read_adapter;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 4;

   logic clk    = 1'b0;
   logic resetn = 1'b0;

   fifo_read_adapter_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

   fifo_read_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   // FIFO environment
   logic [DW:0]   fifo_q [$];
   logic [DW:0]   rdata_r = '0;

   // Behavioural model state
   logic [DW-1:0] m_buf [$];
   bit            m_inflight = 1'b0;
   logic [DW:0]   m_inflight_word = '0;
   logic [CW-1:0] m_words = '0;
   bit            m_perr = 1'b0;
   bit            m_zero = 1'b1;

   // Observations
   logic [DW-1:0] delivered [$];
   int            ren_count = 0;

`ifdef FIFO_RD_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Build a FIFO word whose total XOR over all DW+1 bits equals bad
   function automatic logic [DW:0] mk(input logic [DW-1:0] payload, input bit bad);
      return {(^payload) ^ bad, payload};
   endfunction

   // One clock cycle: drive at negedge, check just after, advance model at posedge
   task automatic step(input bit rdy, input bit rst_n);
      bit exp_valid, exp_pop, exp_ren, ren_obs;
      int credit;
      @(negedge clk);
      resetn         = rst_n;
      bus.out_ready  = rdy;
      bus.fifo_empty = (fifo_q.size() == 0);
      bus.fifo_rdata = rdata_r;
      #1;
      exp_valid = (m_buf.size() != 0);
      exp_pop   = exp_valid && rdy;
      credit    = m_buf.size() + int'(m_inflight) - int'(exp_pop);
      exp_ren   = rst_n && (fifo_q.size() != 0) && (credit < 2);
      chk("fifo_ren",   64'(bus.fifo_ren),   64'(exp_ren));
      chk("out_valid",  64'(bus.out_valid),  64'(exp_valid));
      chk("occupancy",  64'(bus.occupancy),  64'(m_buf.size()));
      chk("words_out",  64'(bus.words_out),  64'(m_words));
      chk("parity_err", 64'(bus.parity_err), 64'(m_perr));
      if (exp_valid)
         chk("out_data", 64'(bus.out_data), 64'(m_buf[0]));
      else if (m_zero)
         chk("out_data_zero", 64'(bus.out_data), 64'(0));
      ren_obs = bus.fifo_ren;
      if (rst_n && bus.out_valid && rdy)
         delivered.push_back(bus.out_data);
      @(posedge clk);
      if (!rst_n) begin
         m_buf.delete();
         m_inflight = 1'b0;
         m_words    = '0;
         m_perr     = 1'b0;
         m_zero     = 1'b1;
      end else begin
         if (exp_pop) begin
            void'(m_buf.pop_front());
            m_words = m_words + CW'(1);
         end
         if (m_inflight) begin
            m_buf.push_back(m_inflight_word[DW-1:0]);
            if (PAR_EN && (^m_inflight_word)) m_perr = 1'b1;
            m_zero = 1'b0;
         end
         m_inflight = 1'b0;
      end
      // Environment follows the reads the DUT actually issued
      if (ren_obs && fifo_q.size() != 0) begin
         rdata_r = fifo_q.pop_front();
         ren_count++;
         if (rst_n) begin
            m_inflight      = 1'b1;
            m_inflight_word = rdata_r;
         end
      end
   endtask

   task automatic push4();
      fifo_q.push_back(mk(32'h11, 1'b0));
      fifo_q.push_back(mk(32'h22, 1'b0));
      fifo_q.push_back(mk(32'h33, 1'b0));
      fifo_q.push_back(mk(32'h44, 1'b0));
   endtask

   task automatic chk_seq(input string tag);
      logic [DW-1:0] exp_w [4];
      exp_w = '{32'h11, 32'h22, 32'h33, 32'h44};
      chk({tag, "_count"}, 64'(delivered.size()), 64'd4);
      for (int i = 0; i < 4; i++)
         if (i < delivered.size()) chk({tag, "_word"}, 64'(delivered[i]), 64'(exp_w[i]));
   endtask

   initial begin
      bus.out_ready  = 1'b0;
      bus.fifo_empty = 1'b1;
      bus.fifo_rdata = '0;
      @(posedge clk);

      // Reset held 3 cycles with a non-empty FIFO
      push4();
      repeat (3) step(1'b1, 1'b0);

      // Streaming with out_ready=1
      ren_count = 0;
      delivered.delete();
      repeat (8) step(1'b1, 1'b1);
      #1;
      chk("stream_ren_count", 64'(ren_count), 64'd4);
      chk("stream_words_out", 64'(bus.words_out), 64'd4);
      chk_seq("stream");

      // Backpressure, then release
      push4();
      ren_count = 0;
      delivered.delete();
      repeat (6) step(1'b0, 1'b1);
      #1;
      chk("bp_ren_count", 64'(ren_count), 64'd2);
      chk("bp_occupancy", 64'(bus.occupancy), 64'd2);
      chk("bp_head",      64'(bus.out_data),  64'h11);
      repeat (10) step(1'b1, 1'b1);
      chk_seq("bp");

      // Empty FIFO: no reads regardless of out_ready
      ren_count = 0;
      for (int i = 0; i < 6; i++) step(1'($urandom_range(0, 1)), 1'b1);
      chk("empty_ren_count", 64'(ren_count), 64'd0);
      delivered.delete();
      fifo_q.push_back(mk(32'h55, 1'b0));
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      #1;
      chk("single_count", 64'(delivered.size()), 64'd1);
      chk("single_occ",   64'(bus.occupancy),    64'd0);

      // Counter wrap with 4-bit counter: 17 words ends at 1
      step(1'b1, 1'b0);
      for (int i = 0; i < 17; i++) fifo_q.push_back(mk(DW'($urandom()), 1'b0));
      repeat (21) step(1'b1, 1'b1);
      #1;
      chk("wrap_words_out", 64'(bus.words_out), 64'd1);

      // Bad-parity word: delivered, flag sticky until reset
      delivered.delete();
      fifo_q.push_back(mk(32'h0000_0F0E, 1'b1));
      repeat (5) step(1'b1, 1'b1);
      #1;
      chk("perr_delivered", 64'(delivered.size()), 64'd1);
      chk("perr_set",       64'(bus.parity_err),   64'(PAR_EN));
      step(1'b1, 1'b0);
      #1;
      chk("perr_cleared",   64'(bus.parity_err),   64'd0);

      // Random traffic with occasional mid-operation reset
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) == 0)
            fifo_q.push_back(mk(DW'($urandom()), ($urandom_range(0, 7) == 0)));
         step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 99) != 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
